// File: rtl/sdram_requester_if.sv
// sdram_requester_if: bundles the host request/response signals and the
// controller-side FIFO signals of sdram_requester.
//   slave  : used by sdram_requester (host + FIFO inputs in, commands/data out)
//   master : used by whoever drives the requester (host and controller model)
// Host side     : req_i/we_i/addr_i/wdata_i -> ready_o, rdata_o/rdata_valid_o,
//                 line_req_i/line_addr_i -> line_ready_o, line_q_o/line_valid_o
// Command side  : cmd_d_o/cmd_enq_o/cmd_alm_full_i, burst_d_o/burst_enq_o/burst_alm_full_i
// Return side   : rd_q_i/rd_empty_i/rd_deq_o, rdb_q_i/rdb_empty_i/rdb_deq_o
// Status        : reads_pending_o, idle_o
interface sdram_requester_if #(
  parameter int MAX_READS = 8
);
  localparam int RPW = $clog2(MAX_READS + 1);

  logic           req_i;
  logic           we_i;
  logic [23:0]    addr_i;
  logic [15:0]    wdata_i;
  logic           ready_o;
  logic [15:0]    rdata_o;
  logic           rdata_valid_o;
  logic           line_req_i;
  logic [23:0]    line_addr_i;
  logic           line_ready_o;
  logic [127:0]   line_q_o;
  logic           line_valid_o;
  logic [40:0]    cmd_d_o;
  logic           cmd_enq_o;
  logic           cmd_alm_full_i;
  logic [31:0]    burst_d_o;
  logic           burst_enq_o;
  logic           burst_alm_full_i;
  logic [15:0]    rd_q_i;
  logic           rd_empty_i;
  logic           rd_deq_o;
  logic [127:0]   rdb_q_i;
  logic           rdb_empty_i;
  logic           rdb_deq_o;
  logic [RPW-1:0] reads_pending_o;
  logic           idle_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, line_req_i, line_addr_i,
           cmd_alm_full_i, burst_alm_full_i, rd_q_i, rd_empty_i, rdb_q_i, rdb_empty_i,
    output ready_o, rdata_o, rdata_valid_o, line_ready_o, line_q_o, line_valid_o,
           cmd_d_o, cmd_enq_o, burst_d_o, burst_enq_o, rd_deq_o, rdb_deq_o,
           reads_pending_o, idle_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, line_req_i, line_addr_i,
           cmd_alm_full_i, burst_alm_full_i, rd_q_i, rd_empty_i, rdb_q_i, rdb_empty_i,
    input  ready_o, rdata_o, rdata_valid_o, line_ready_o, line_q_o, line_valid_o,
           cmd_d_o, cmd_enq_o, burst_d_o, burst_enq_o, rd_deq_o, rdb_deq_o,
           reads_pending_o, idle_o
  );
endinterface

// File: rtl/sdram_requester.sv
// sdram_requester: client-side endpoint of async_sdram_ctrl.
// Packs host word requests into 41-bit commands and line requests into burst
// address commands, pops the controller's show-ahead return FIFOs into
// one-cycle valid pulses, and counts reads in flight for flow control.
// Ports:
//   clk     : client clock (also the controller's writer/reader clock)
//   rst_n_i : asynchronous active-low reset
//   bus     : sdram_requester_if.slave, all request/command/return signals

// Outstanding-request counter: +1 on accept, -1 on pop, saturating at 0 so
// stale returns after a reset are still drained without wrapping.
module sdram_pend_cnt #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) r_cnt <= '0;
    else begin
      case ({i_inc, i_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt = r_cnt;
endmodule

// Return-FIFO popper: captures the fall-through head and pulses valid/dequeue
// together, then spends one cycle in R_POP so the FIFO's empty flag and head
// reflect the pop before the next capture.
module sdram_rsp_pop #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         i_empty,
  input  logic [W-1:0] i_q,
  output logic [W-1:0] o_q,
  output logic         o_pulse
);
  typedef enum logic {R_IDLE = 1'b0, R_POP = 1'b1} st_t;

  st_t          r_st, w_nxt;
  logic         w_take;
  logic         r_pulse;
  logic [W-1:0] r_q;

  always_comb begin
    w_nxt  = r_st;
    w_take = 1'b0;
    case (r_st)
      R_IDLE: if (!i_empty) begin
        w_take = 1'b1;
        w_nxt  = R_POP;
      end
      R_POP:  w_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_st    <= R_IDLE;
      r_pulse <= 1'b0;
      r_q     <= '0;
    end else begin
      r_st    <= w_nxt;
      r_pulse <= w_take;
      if (w_take) r_q <= i_q;  // data holds between pulses
    end
  end

  assign o_q     = r_q;
  assign o_pulse = r_pulse;
endmodule

module sdram_requester #(
  parameter int MAX_READS = 8,
  parameter int MAX_LINES = 2
) (
  input  logic                clk,
  input  logic                rst_n_i,
  sdram_requester_if.slave    bus
);
  localparam int RPW = $clog2(MAX_READS + 1);
  localparam int LPW = $clog2(MAX_LINES + 1);

  logic [RPW-1:0] w_rd_pend;
  logic [LPW-1:0] w_ln_pend;
  logic           w_rd_pulse, w_ln_pulse;
  logic           w_acc, w_rd_acc, w_ln_acc;
  logic           r_cmd_enq, r_burst_enq;
  logic [40:0]    r_cmd_d;
  logic [31:0]    r_burst_d;

  // Almost-full covers the cycle between our registered enqueue and the
  // FIFO's own full flag catching up.
  assign bus.ready_o      = !bus.cmd_alm_full_i &&
                            (bus.we_i || (w_rd_pend < RPW'(MAX_READS)));
  assign bus.line_ready_o = !bus.burst_alm_full_i && (w_ln_pend < LPW'(MAX_LINES));

  assign w_acc    = bus.req_i && bus.ready_o;
  assign w_rd_acc = w_acc && !bus.we_i;
  assign w_ln_acc = bus.line_req_i && bus.line_ready_o;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cmd_enq   <= 1'b0;
      r_cmd_d     <= '0;
      r_burst_enq <= 1'b0;
      r_burst_d   <= '0;
    end else begin
      r_cmd_enq   <= w_acc;
      r_burst_enq <= w_ln_acc;
      if (w_acc)
        r_cmd_d <= {bus.we_i, bus.addr_i, bus.we_i ? bus.wdata_i : 16'h0};
      if (w_ln_acc)
        r_burst_d <= {8'h0, bus.line_addr_i[23:3], 3'b000};
    end
  end

  sdram_pend_cnt #(.MAX(MAX_READS)) u_rd_cnt (
    .clk(clk), .rst_n_i(rst_n_i), .i_inc(w_rd_acc), .i_dec(w_rd_pulse), .o_cnt(w_rd_pend)
  );

  sdram_pend_cnt #(.MAX(MAX_LINES)) u_ln_cnt (
    .clk(clk), .rst_n_i(rst_n_i), .i_inc(w_ln_acc), .i_dec(w_ln_pulse), .o_cnt(w_ln_pend)
  );

  sdram_rsp_pop #(.W(16)) u_rd_pop (
    .clk(clk), .rst_n_i(rst_n_i), .i_empty(bus.rd_empty_i), .i_q(bus.rd_q_i),
    .o_q(bus.rdata_o), .o_pulse(w_rd_pulse)
  );

  sdram_rsp_pop #(.W(128)) u_ln_pop (
    .clk(clk), .rst_n_i(rst_n_i), .i_empty(bus.rdb_empty_i), .i_q(bus.rdb_q_i),
    .o_q(bus.line_q_o), .o_pulse(w_ln_pulse)
  );

  assign bus.rdata_valid_o   = w_rd_pulse;
  assign bus.rd_deq_o        = w_rd_pulse;
  assign bus.line_valid_o    = w_ln_pulse;
  assign bus.rdb_deq_o       = w_ln_pulse;
  assign bus.cmd_enq_o       = r_cmd_enq;
  assign bus.cmd_d_o         = r_cmd_d;
  assign bus.burst_enq_o     = r_burst_enq;
  assign bus.burst_d_o       = r_burst_d;
  assign bus.reads_pending_o = w_rd_pend;
  assign bus.idle_o          = (w_rd_pend == '0) && (w_ln_pend == '0) &&
                               !r_cmd_enq && !r_burst_enq;
endmodule

// File: doc/sdram_requester.md
# sdram_requester

Client-side endpoint of `async_sdram_ctrl`, sitting in the client clock domain that drives both its writer and reader ports. It turns a simple host request interface into packed single-word commands and 8-word burst line commands. It pops returned words and lines from the controller's show-ahead output FIFOs, presents them to the host as one-cycle valid pulses, and tracks outstanding reads for flow control.

## Interface
- `MAX_READS`, 8: maximum single-word reads in flight (accepted but not yet popped).
- `MAX_LINES`, 2: maximum burst line reads in flight.
- `clk` in 1: client clock; it drives both the writer and reader clocks of the controller.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `req_i` in 1: single-word request.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 24: word address.
- `wdata_i` in 16: write data.
- `ready_o` out 1: combinational accept for the request.
- `rdata_o` out 16: returned read word.
- `rdata_valid_o` out 1: one-cycle pulse qualifying `rdata_o`.
- `line_req_i` in 1: line read request.
- `line_addr_i` in 24: line word address; bits [2:0] are ignored.
- `line_ready_o` out 1: combinational accept for the line request.
- `line_q_o` out 128: returned line; first word in [127:112].
- `line_valid_o` out 1: one-cycle pulse qualifying `line_q_o`.
- `cmd_d_o` out 41: `{we, addr[23:0], data[15:0]}`.
- `cmd_enq_o` out 1: command FIFO enqueue.
- `cmd_alm_full_i` in 1: command FIFO almost full.
- `burst_d_o` out 32: burst command address.
- `burst_enq_o` out 1: burst command FIFO enqueue.
- `burst_alm_full_i` in 1: burst command FIFO almost full.
- `rd_q_i` in 16: head of the word FIFO.
- `rd_empty_i` in 1: word FIFO empty.
- `rd_deq_o` out 1: word FIFO dequeue.
- `rdb_q_i` in 128: head of the line FIFO.
- `rdb_empty_i` in 1: line FIFO empty.
- `rdb_deq_o` out 1: line FIFO dequeue.
- `reads_pending_o` out `$clog2(MAX_READS+1)`: single-word reads in flight.
- `idle_o` out 1: no reads or lines in flight and no enqueue pulse active.

## Operation
- **Reset.** All registered outputs and counters are 0. `idle_o` is 1 during reset.
- **Word request acceptance.**
  - `ready_o = !cmd_alm_full_i && (we_i || reads_pending_o < MAX_READS)`.
  - On `req_i && ready_o`, register `cmd_d_o = {we_i, addr_i, we_i ? wdata_i : 16'h0}` and pulse `cmd_enq_o`.
  - Using the almost-full flag covers the one-cycle lag between the registered enqueue and the full flag.
- **Read counter.**
  - Increments on an accepted read (`we_i=0`).
  - Decrements on an `rd_deq_o` pulse.
  - Increment and decrement in the same cycle leave it unchanged.
  - A decrement at 0 saturates at 0: stale data after a reset is still delivered.
- **Line request acceptance.**
  - `line_ready_o = !burst_alm_full_i && lines_pending < MAX_LINES`.
  - On accept, register `burst_d_o = {8'h0, line_addr_i[23:3], 3'b000}` and pulse `burst_enq_o`.
  - The line counter follows the same rules as the read counter, using `rdb_deq_o`.
- **Independent paths.** The word and line request paths may accept in the same cycle.
- **Word response FSM.**
  - `R_IDLE`: when `!rd_empty_i`, register `rdata_o <= rd_q_i`, `rdata_valid_o <= 1`, `rd_deq_o <= 1`, then go to `R_POP`.
  - `R_POP`: clear `rdata_valid_o` and `rd_deq_o`, then go to `R_IDLE`.
  - The FIFOs are first-word-fall-through, so the head is captured before the pop takes effect.
- **Line response FSM.** Identical structure on `rdb_*`, driving `line_q_o` and `line_valid_o`.
- **Data hold.** `rdata_o` and `line_q_o` hold their last value between pulses.
- **Ordering.** Word data returns in request order, and line data returns in request order. There is no ordering guarantee between the word stream and the line stream.
- **Reset mid-operation.** Reset clears counters and FSMs immediately. Responses arriving afterwards are still popped and delivered.

## Timing
- Request accepted at edge N: `cmd_enq_o` or `burst_enq_o` is high for cycle N+1 only. One accept per cycle per path.
- Response: first cycle with the FIFO non-empty (edge M) gives `rdata_valid_o` high in cycle M+1. Maximum throughput is one word or line per 2 cycles per path.
- `ready_o` and `line_ready_o` are combinational from their inputs and the counters.
- `reads_pending_o` updates one cycle after the accept or dequeue event.

## Test plan
- **Reset.** Assert `rst_n_i=0` mid-burst. Required: all enqueue, dequeue and valid outputs are 0 asynchronously, counters are 0 and `idle_o=1`.
- **Write.** `we_i=1`, `addr_i=24'h123456`, `wdata_i=16'hBEEF`. Required: `cmd_d_o=41'h1_123456_BEEF` with `cmd_enq_o` high for exactly one cycle, and `reads_pending_o` stays 0.
- **Read flow control.** Issue 9 back-to-back reads with `MAX_READS=8` and no returns. Required: 8 accepted, `ready_o=0` on the 9th. After one word is returned, `ready_o=1` for reads and the data is delivered in order.
- **Line.** `line_addr_i=24'h00001F` accepted, giving `burst_d_o=32'h0000_0018`. Then load `rdb_q_i=128'h0001_0002_..._0008`. Required: `line_valid_o` pulses once with that value and `rdb_deq_o` pulses once.
- **Simultaneous events.** Accept a read in the same cycle as a word dequeue with the count at 3. Required: count stays 3. Also drive `cmd_alm_full_i=1` with a write pending. Required: no enqueue and `ready_o=0`.
- **Streaming.** Keep `rd_empty_i=0` for 6 words. Required: `rd_deq_o` and `rdata_valid_o` pulse on alternate cycles, exactly 6 pulses, with no data skipped or duplicated.
